// File: rtl/csa_seq_pkg.sv
// Shared types and sizing helpers for the multi-word carry-select sequencer.
package csa_seq_pkg;
  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  function automatic int nslice_f(input int width);
    return width / SLICE_W;
  endfunction

  // Counter is at least one bit so WIDTH==16 still has a legal idx register.
  function automatic int idx_w_f(input int width);
    int n;
    n = width / SLICE_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/csa_multiword_sequencer_if.sv
// Operand/result handshake bundle; optional ovf output under CSA_SEQ_OVF_EN.
interface csa_multiword_sequencer_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CSA_SEQ_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/csa_slice16.sv
// Combinational 16-bit carry-select adder built from 4-bit blocks.
module csa_slice16
  import csa_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  localparam int BLK  = 4;
  localparam int NBLK = SLICE_W / BLK;

  logic [NBLK:0] c;
  assign c[0] = cin;

  genvar g;
  for (g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] s0, s1;
    // Both carry hypotheses are formed up front; the incoming carry only muxes.
    assign s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign s1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + (BLK+1)'(1);
    assign sum[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign c[g+1]            = c[g] ? s1[BLK]     : s0[BLK];
  end

  assign cout = c[NBLK];
endmodule

// File: rtl/csa_multiword_sequencer.sv
// WIDTH-bit adder that walks one csa_slice16 across the operands, LSB slice first.
// Optional signed-overflow output is enabled by defining CSA_SEQ_OVF_EN.
module csa_multiword_sequencer
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic                      clk,
  input logic                      rst,
  csa_multiword_sequencer_if.slave bus
);
  localparam int NSLICE = nslice_f(WIDTH);
  localparam int IDX_W  = idx_w_f(WIDTH);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("csa_multiword_sequencer: WIDTH must be a multiple of 16 and >= 16");
  end

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout;
  logic               last;

  assign sl_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign sl_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign last = (idx_q == IDX_W'(NSLICE-1));

  csa_slice16 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.sum       = sum_q;
    bus.cout      = carry_q;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      // Result drains back to IDLE before any new accept.
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          carry_q <= bus.cin;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[int'(idx_q)*SLICE_W +: SLICE_W] <= sl_sum;
          carry_q <= sl_cout;
          idx_q   <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_SEQ_OVF_EN
  assign bus.ovf = bus.out_valid && (a_q[WIDTH-1] == b_q[WIDTH-1])
                   && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
`endif
endmodule
